// File: rtl/host_descriptor_merge_pkg.sv
// Shared constants, merge FSM state encoding and helpers for the host
// descriptor merge stage.
package host_descriptor_merge_pkg;

  localparam int DESC_W  = 46;
  localparam int CNT_W   = 8;
  localparam int CLS_TS  = 0;
  localparam int CLS_NTS = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } merge_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/host_descriptor_merge_fifo.sv
// Small descriptor FIFO: registered write, first-word-fall-through read,
// occupancy reaches DEPTH when full.
module descriptor_fifo
  import host_descriptor_merge_pkg::*;
#(
  parameter int W      = DESC_W,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [W-1:0]      i_wr_data,
  input  logic              i_rd_en,
  output logic [W-1:0]      o_rd_data,
  output logic [ADDR_W:0]   o_usedw,
  output logic              o_full,
  output logic              o_empty
);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              push, pop;

  assign o_full  = (cnt_q == (ADDR_W+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign push    = i_wr_en & ~o_full;
  assign pop     = i_rd_en & ~o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (ADDR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (ADDR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_wr_data;
  end

  // Head is visible combinationally so the arbiter can pop and capture in one edge.
  assign o_rd_data = mem[rd_ptr_q];
  assign o_usedw   = cnt_q;

endmodule

// File: rtl/host_descriptor_merge.sv
// Merges buffered TS and NTS descriptors onto one tagged stream with strict
// TS priority and a starvation guard that periodically forces an NTS grant.
module host_descriptor_merge
  import host_descriptor_merge_pkg::*;
#(
  parameter int DESC_W       = host_descriptor_merge_pkg::DESC_W,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DESC_W-1:0] iv_ts_descriptor,
  input  logic              i_ts_descriptor_wr,
  output logic              o_ts_descriptor_ack,
  input  logic [DESC_W-1:0] iv_nts_descriptor,
  input  logic              i_nts_descriptor_wr,
  output logic              o_nts_descriptor_ack,
  output logic [DESC_W:0]   ov_descriptor,
  output logic              o_descriptor_wr,
  input  logic              i_descriptor_ack,
  output logic [ADDR_W:0]   ov_ts_fifo_usedw,
  output logic [ADDR_W:0]   ov_nts_fifo_usedw,
  output logic              o_starve_grant_pulse,
  output logic [1:0]        merge_state
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [1:0]        in_wr, ack_q, ack_d, pop, fifo_empty, fifo_full;
  logic [DESC_W-1:0] in_desc [2];
  logic [DESC_W-1:0] rd_data [2];
  logic [ADDR_W:0]   usedw   [2];

  assign in_wr[CLS_TS]    = i_ts_descriptor_wr;
  assign in_wr[CLS_NTS]   = i_nts_descriptor_wr;
  assign in_desc[CLS_TS]  = iv_ts_descriptor;
  assign in_desc[CLS_NTS] = iv_nts_descriptor;

  // Accept only when ack is low, so a wr still held during its ack cycle never writes twice.
  always_comb begin
    ack_d = '0;
    for (int c = 0; c < 2; c++) begin
      ack_d[c] = in_wr[c] & ~ack_q[c] & ~fifo_full[c];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cls
      descriptor_fifo #(
        .W      (DESC_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
      ) u_fifo (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (ack_d[gi]),
        .i_wr_data (in_desc[gi]),
        .i_rd_en   (pop[gi]),
        .o_rd_data (rd_data[gi]),
        .o_usedw   (usedw[gi]),
        .o_full    (fifo_full[gi]),
        .o_empty   (fifo_empty[gi])
      );
    end
  endgenerate

  merge_state_e      state_q, state_d;
  logic              out_wr_q, out_wr_d;
  logic [DESC_W:0]   desc_q, desc_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              pulse_q, pulse_d;
  logic              ts_avail, nts_avail, force_nts;

  assign ts_avail  = ~fifo_empty[CLS_TS];
  assign nts_avail = ~fifo_empty[CLS_NTS];
  assign force_nts = (starve_q == LIMIT) && nts_avail;

  always_comb begin
    state_d  = state_q;
    out_wr_d = out_wr_q;
    desc_d   = desc_q;
    starve_d = starve_q;
    pulse_d  = 1'b0;
    pop      = '0;
    case (state_q)
      ST_IDLE: begin
        if (ts_avail || nts_avail) begin
          if (ts_avail && !force_nts) begin
            pop[CLS_TS] = 1'b1;
            desc_d      = {1'b1, rd_data[CLS_TS]};
            starve_d    = nts_avail ? sat_inc(starve_q) : '0;
          end else begin
            pop[CLS_NTS] = 1'b1;
            desc_d       = {1'b0, rd_data[CLS_NTS]};
            starve_d     = '0;
            pulse_d      = force_nts;
          end
          out_wr_d = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_descriptor_ack) begin
          out_wr_d = 1'b0;
          state_d  = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: begin
        state_d  = ST_IDLE;
        out_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ack_q    <= '0;
      state_q  <= ST_IDLE;
      out_wr_q <= 1'b0;
      desc_q   <= '0;
      starve_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      state_q  <= state_d;
      out_wr_q <= out_wr_d;
      desc_q   <= desc_d;
      starve_q <= starve_d;
      pulse_q  <= pulse_d;
    end
  end

  assign o_ts_descriptor_ack  = ack_q[CLS_TS];
  assign o_nts_descriptor_ack = ack_q[CLS_NTS];
  assign ov_descriptor        = desc_q;
  assign o_descriptor_wr      = out_wr_q;
  assign ov_ts_fifo_usedw     = usedw[CLS_TS];
  assign ov_nts_fifo_usedw    = usedw[CLS_NTS];
  assign o_starve_grant_pulse = pulse_q;
  assign merge_state          = state_q;

endmodule

// File: tb/tb_host_descriptor_merge.sv
// Directed self-checking bench for host_descriptor_merge.
module tb_host_descriptor_merge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [45:0] ts_desc, nts_desc;
  logic        ts_wr, nts_wr, dack;
  logic        ts_ack, nts_ack, o_wr, pulse;
  logic [46:0] ov;
  logic [2:0]  ts_usedw, nts_usedw;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  host_descriptor_merge dut (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .iv_ts_descriptor     (ts_desc),
    .i_ts_descriptor_wr   (ts_wr),
    .o_ts_descriptor_ack  (ts_ack),
    .iv_nts_descriptor    (nts_desc),
    .i_nts_descriptor_wr  (nts_wr),
    .o_nts_descriptor_ack (nts_ack),
    .ov_descriptor        (ov),
    .o_descriptor_wr      (o_wr),
    .i_descriptor_ack     (dack),
    .ov_ts_fifo_usedw     (ts_usedw),
    .ov_nts_fifo_usedw    (nts_usedw),
    .o_starve_grant_pulse (pulse),
    .merge_state          (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_ts(input logic [45:0] d, input string tag);
    int k;
    ts_desc = d;
    ts_wr   = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!ts_ack && k < 20);
    chk(tag, ts_ack, 1);
    ts_wr = 1'b0;
  endtask

  task automatic pop_check(input logic [46:0] exp, input string tag);
    int k;
    k = 0;
    while (!o_wr && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_wr"}, o_wr, 1);
    chk(tag, ov, exp);
    dack = 1'b1;
    tick();
    dack = 1'b0;
  endtask

  initial begin
    int  grants;
    int  k;
    bit  exp_nts;
    logic [15:0] ts_seq;

    rst_n = 1'b0; ts_desc = '0; nts_desc = '0;
    ts_wr = 1'b0; nts_wr = 1'b0; dack = 1'b0;
    repeat (3) tick();
    chk("rst_out_wr", o_wr, 0);
    chk("rst_desc", ov, 0);
    chk("rst_ts_usedw", ts_usedw, 0);
    chk("rst_nts_usedw", nts_usedw, 0);
    chk("rst_state", state, 0);
    chk("rst_acks", {ts_ack, nts_ack, pulse}, 0);
    rst_n = 1'b1;
    tick();

    // Single TS descriptor, wr held through its ack cycle
    ts_desc = 46'h2A_0000_0001; ts_wr = 1'b1;
    tick();
    chk("t1_ack", ts_ack, 1);
    chk("t1_usedw", ts_usedw, 1);
    chk("t1_out_early", o_wr, 0);
    tick();
    ts_wr = 1'b0;
    chk("t1_ack_pulse", ts_ack, 0);
    chk("t1_no_double", ts_usedw, 0);
    chk("t1_out_wr", o_wr, 1);
    chk("t1_out_desc", ov, {1'b1, 46'h2A_0000_0001});
    chk("t1_state_send", state, 1);
    tick();
    tick();
    chk("t1_hold", o_wr, 1);
    dack = 1'b1;
    tick();
    dack = 1'b0;
    chk("t1_wr_low", o_wr, 0);
    chk("t1_state_gap", state, 2);
    tick();
    chk("t1_state_idle", state, 0);

    // TS and NTS in the same cycle
    ts_desc = 46'h11_1111_1111; nts_desc = 46'h22_2222_2222;
    ts_wr = 1'b1; nts_wr = 1'b1;
    tick();
    chk("t2_ts_ack", ts_ack, 1);
    chk("t2_nts_ack", nts_ack, 1);
    ts_wr = 1'b0; nts_wr = 1'b0;
    tick();
    chk("t2_first_wr", o_wr, 1);
    chk("t2_first_ts", ov, {1'b1, 46'h11_1111_1111});
    dack = 1'b1;
    tick();
    dack = 1'b0;
    chk("t2_gap_wr", o_wr, 0);
    tick();
    chk("t2_idle_wr", o_wr, 0);
    tick();
    chk("t2_second_wr", o_wr, 1);
    chk("t2_second_nts", ov, {1'b0, 46'h22_2222_2222});
    dack = 1'b1;
    tick();
    dack = 1'b0;
    tick();

    // Output stalled: one TS in the output register, then 5 more pushed
    push_ts(46'h30, "t3_ack0");
    push_ts(46'h31, "t3_ack1");
    push_ts(46'h32, "t3_ack2");
    push_ts(46'h33, "t3_ack3");
    push_ts(46'h34, "t3_ack4");
    tick();
    chk("t3_full_usedw", ts_usedw, 4);
    chk("t3_out_head", ov, {1'b1, 46'h30});
    ts_desc = 46'h35; ts_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_held_no_ack", ts_ack, 0);
    end
    chk("t3_held_usedw", ts_usedw, 4);
    dack = 1'b1;
    tick();
    dack = 1'b0;
    k = 0;
    while (!ts_ack && k < 10) begin
      tick();
      k++;
    end
    chk("t3_late_ack", ts_ack, 1);
    ts_wr = 1'b0;
    pop_check({1'b1, 46'h31}, "t3_pop1");
    pop_check({1'b1, 46'h32}, "t3_pop2");
    pop_check({1'b1, 46'h33}, "t3_pop3");
    pop_check({1'b1, 46'h34}, "t3_pop4");
    pop_check({1'b1, 46'h35}, "t3_pop5");
    tick();
    tick();
    chk("t3_empty", ts_usedw, 0);

    // Starvation guard: continuous TS with NTS pending
    ts_seq = 16'h100;
    ts_desc = {30'h0, ts_seq}; ts_wr = 1'b1;
    nts_desc = 46'h3_0000_0000; nts_wr = 1'b1;
    grants = 0;
    for (int cyc = 0; cyc < 400 && grants < 18; cyc++) begin
      tick();
      if (nts_ack) nts_wr = 1'b0;
      if (ts_ack) begin
        ts_seq++;
        ts_desc = {30'h0, ts_seq};
      end
      if (dack) begin
        dack = 1'b0;
      end else if (o_wr) begin
        grants++;
        exp_nts = (grants == 9) || (grants == 18);
        chk("t4_class", ov[46], !exp_nts);
        chk("t4_pulse", pulse, exp_nts);
        if (grants == 9) begin
          nts_desc = 46'h3_0000_0001;
          nts_wr   = 1'b1;
        end
        dack = 1'b1;
      end
    end
    chk("t4_grants", grants, 18);
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      if (ts_ack) ts_wr = 1'b0;
      if (dack) dack = 1'b0;
      else if (o_wr) dack = 1'b1;
      if (!ts_wr && !o_wr && !dack && ts_usedw == 0 && nts_usedw == 0 && state == 0) break;
    end
    chk("t4_drained_ts", ts_usedw, 0);
    chk("t4_drained_state", state, 0);

    // Push and pop on the TS FIFO in the same cycle at usedw=2
    push_ts(46'h50, "t5_ack0");
    push_ts(46'h51, "t5_ack1");
    push_ts(46'h52, "t5_ack2");
    tick();
    chk("t5_usedw_pre", ts_usedw, 2);
    chk("t5_out_head", ov, {1'b1, 46'h50});
    dack = 1'b1;
    tick();
    dack = 1'b0;
    tick();
    chk("t5_idle", state, 0);
    chk("t5_usedw_idle", ts_usedw, 2);
    ts_desc = 46'h53; ts_wr = 1'b1;
    tick();
    ts_wr = 1'b0;
    chk("t5_ack3", ts_ack, 1);
    chk("t5_usedw_same", ts_usedw, 2);
    chk("t5_out_next", ov, {1'b1, 46'h51});
    pop_check({1'b1, 46'h51}, "t5_pop1");
    pop_check({1'b1, 46'h52}, "t5_pop2");
    pop_check({1'b1, 46'h53}, "t5_pop3");
    tick();
    tick();

    // Reset during SEND with three descriptors queued
    push_ts(46'h70, "t6_ack0");
    push_ts(46'h71, "t6_ack1");
    push_ts(46'h72, "t6_ack2");
    push_ts(46'h73, "t6_ack3");
    tick();
    chk("t6_usedw_pre", ts_usedw, 3);
    chk("t6_state_send", state, 1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_out_wr", o_wr, 0);
    chk("t6_rst_desc", ov, 0);
    chk("t6_rst_usedw", {ts_usedw, nts_usedw}, 0);
    chk("t6_rst_state", state, 0);
    chk("t6_rst_flags", {ts_ack, nts_ack, pulse}, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6_post_out_wr", o_wr, 0);
    chk("t6_post_usedw", ts_usedw, 0);
    chk("t6_post_state", state, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
